display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 disp_en  in  1  display enable; 0 blanks all digits.
REQ-005 lz_blank  in  1  leading-zero blanking enable.
REQ-006 in_valid  in  1  new display value offered.
REQ-007 in_data  in  16  four hex digits; [3:0] is the rightmost digit.
REQ-008 in_ready  out  1  controller can accept in_data.
REQ-009 frame_done  out  1  one-cycle pulse at each frame boundary.
REQ-010 LED_out  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Anode_Activate  out  4  digit selects, active-low; bit 0 is the rightmost digit.

Function
REQ-012 The FSM SHALL have states OFF and SCAN; in OFF it SHALL drive Anode_Activate=4'b1111 and LED_out=7'b1111111.
REQ-013 OFF->SCAN when disp_en=1, with tick counter=0 and digit index=0; SCAN->OFF on the first cycle disp_en=0, and the outputs SHALL be blank one cycle later.
REQ-014 In SCAN, the tick counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on a wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-015 Frame boundary = a tick wrap while the digit index is 3; frame_done SHALL pulse high for exactly that cycle.
REQ-016 LED_out and Anode_Activate SHALL be registered; they SHALL reflect a new digit index one cycle after the index changes.
REQ-017 Exactly one anode SHALL be low in SCAN, unless that digit is blanked.
REQ-018 Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 Handshake: a transfer occurs when in_valid && in_ready; in_data SHALL be captured into a pending register and in_ready SHALL go low the next cycle.
REQ-020 The pending value SHALL be committed to the display register at the first frame boundary strictly after the capture cycle; in_ready SHALL return high the cycle after the commit.
REQ-021 A capture coinciding with a frame boundary SHALL commit at the following boundary, never mid-frame; the displayed value SHALL never change within a frame.
REQ-022 While in OFF, a pending value SHALL commit immediately on the next cycle, since there is no frame to tear.
REQ-023 With lz_blank=1, any digit above the highest non-zero nibble of the display register SHALL have its anode held high; digit 0 is never blanked (0x0000 shows "0").
REQ-024 lz_blank SHALL be evaluated per digit slot, so a change takes effect at the next slot.

Reset
REQ-025 On reset=0: state=OFF, counter=0, digit index=0, display register=16'h0000, pending empty, in_ready=1, frame_done=0, Anode_Activate=4'b1111, LED_out=7'b1111111.
REQ-026 Reset asserted mid-operation SHALL discard any pending value and blank the outputs immediately (asynchronously).
REQ-027 After reset deasserts, the first capture SHALL be possible on the first rising edge.

Structure
REQ-028 Package display_pkg SHALL hold NUM_DIGITS=4, the 16-entry segment table, the SEG_BLANK/AN_OFF constants, and the FSM state typedef.
REQ-029 The hex decoder SHALL be a separate combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out).

Verification (REFRESH_DIV=4)
REQ-030 Reset, then disp_en=1 with no load -> anodes cycle 1110,1101,1011,0111 every 4 cycles, each digit showing 1000000; frame_done pulses every 16 cycles.
REQ-031 Load 16'h12AF mid-frame -> in_ready low; display stays 0000 until frame_done; the next frame shows digit0=0001110, digit1=0001000, digit2=0100100, digit3=1111001; in_ready high one cycle after commit.
REQ-032 in_valid held high with a second value while in_ready=0 -> no capture; the second value is captured after in_ready rises and committed at the subsequent boundary.
REQ-033 lz_blank=1 with value 16'h0030 -> anodes 3 and 2 stay high, digit1 shows 0110000, digit0 shows 1000000; value 16'h0000 -> only digit 0 is lit.
REQ-034 disp_en dropped mid-slot -> outputs blank one cycle later; load 16'h00FF while OFF -> committed the next cycle; re-enable -> scan restarts at digit 0 showing 0001110.
REQ-035 reset pulsed low while a value is pending -> outputs blank with no clock edge; after release, in_ready=1 and the display register reads 0000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, segment table and FSM state type for the display scanner.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  // All segments dark (active-low) and all anodes deselected (active-low).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex value (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [0:0] {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Nibble of a four-digit value selected by digit index (0 is rightmost).
  function automatic logic [3:0] nibble_at(input logic [15:0] value, input logic [1:0] idx);
    logic [3:0] nib;
    nib = value[3:0];
    case (idx)
      2'd0: nib = value[3:0];
      2'd1: nib = value[7:4];
      2'd2: nib = value[11:8];
      2'd3: nib = value[15:12];
      default: nib = value[3:0];
    endcase
    return nib;
  endfunction

  // True when the digit and every digit to its left are zero; the rightmost
  // digit is never considered a leading zero so 0x0000 still shows "0".
  function automatic logic is_leading_zero(input logic [15:0] value, input logic [1:0] idx);
    logic lead;
    lead = 1'b0;
    case (idx)
      2'd0: lead = 1'b0;
      2'd1: lead = (value[15:4] == 12'h000);
      2'd2: lead = (value[15:8] == 8'h00);
      2'd3: lead = (value[15:12] == 4'h0);
      default: lead = 1'b0;
    endcase
    return lead;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup; every 4-bit code has a defined glyph.
  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a tear-free
// value load handshake and optional leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_en,
  input  logic        lz_blank,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        frame_done,
  output logic [6:0]  LED_out,
  output logic [3:0]  Anode_Activate
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [1:0]       digit_q, digit_d;
  logic             lz_q, lz_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [6:0]       led_q, led_d;
  logic [3:0]       an_q, an_d;

  logic             tick_wrap;
  logic             frame_boundary;
  logic             accept;
  logic             blank_digit;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;

  assign tick_wrap      = (state_q == ST_SCAN) && (tick_q == TICK_LAST);
  assign frame_boundary = tick_wrap && (digit_q == 2'd3);
  assign in_ready       = !pend_valid_q;
  assign accept         = in_valid && in_ready;
  assign frame_done     = frame_boundary;
  assign LED_out        = led_q;
  assign Anode_Activate = an_q;

  assign cur_nibble  = nibble_at(disp_q, digit_q);
  assign blank_digit = lz_q && is_leading_zero(disp_q, digit_q);

  hex_to_seg7 u_dec (
    .hex (cur_nibble),
    .seg (cur_seg)
  );

  // Scan FSM: slot timer, digit index and the per-slot blanking sample.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    digit_d = digit_q;
    lz_d    = lz_q;
    case (state_q)
      ST_OFF: begin
        tick_d  = '0;
        digit_d = 2'd0;
        lz_d    = lz_blank;
        if (disp_en) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!disp_en) begin
          state_d = ST_OFF;
          tick_d  = '0;
          digit_d = 2'd0;
        end else if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          digit_d = digit_q + 2'd1;
          lz_d    = lz_blank;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        tick_d  = '0;
        digit_d = 2'd0;
      end
    endcase
  end

  // Load path: capture into the pending slot, commit only between frames
  // (or at once while dark, where nothing can tear).
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;
    if (pend_valid_q && ((state_q == ST_OFF) || frame_boundary)) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end
    if (accept) begin
      pend_d       = in_data;
      pend_valid_d = 1'b1;
    end
  end

  // Output drive for the current slot; disp_en low darkens on the next edge.
  always_comb begin
    an_d  = AN_OFF;
    led_d = SEG_BLANK;
    if ((state_q == ST_SCAN) && disp_en && !blank_digit) begin
      an_d  = ~(4'b0001 << digit_q);
      led_d = cur_seg;
    end
  end

  // State registers; reset blanks the outputs and drops any pending value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_OFF;
      tick_q       <= '0;
      digit_q      <= 2'd0;
      lz_q         <= 1'b0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      led_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      digit_q      <= digit_d;
      lz_q         <= lz_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      led_q        <= led_d;
      an_q         <= an_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with REFRESH_DIV=4.
module tb_display_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        disp_en;
  logic        lz_blank;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        frame_done;
  logic [6:0]  LED_out;
  logic [3:0]  Anode_Activate;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] SB = 7'b1111111;

  display_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .disp_en        (disp_en),
    .lz_blank       (lz_blank),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .frame_done     (frame_done),
    .LED_out        (LED_out),
    .Anode_Activate (Anode_Activate)
  );

  // 100 MHz-style clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench always ends.
  initial begin
    #50000;
    $display("[TB] FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [3:0] an, input logic [6:0] led);
    check({tag, ".anode"}, {12'h000, Anode_Activate}, {12'h000, an});
    check({tag, ".led"}, {9'h000, LED_out}, {9'h000, led});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame_done(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) found = 1'b1;
    end
    check(tag, {15'h0000, found}, 16'h0001);
  endtask

  initial begin
    reset    = 1'b1;
    disp_en  = 1'b0;
    lz_blank = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;

    // Reset state
    #1 reset = 1'b0;
    #1;
    check_disp("rst", 4'b1111, SB);
    check("rst.in_ready", {15'h0, in_ready}, 16'h0001);
    check("rst.frame_done", {15'h0, frame_done}, 16'h0000);
    tick(2);
    #4;
    reset   = 1'b1;
    disp_en = 1'b1;

    // Free-running scan of 0000: 4 cycles per digit, frame_done every 16
    tick(1);
    check_disp("scan.e1", 4'b1111, SB);
    for (int k = 2; k <= 33; k++) begin
      int d;
      tick(1);
      d = ((k - 2) / 4) % 4;
      check_disp("scan", ~(4'b0001 << d), S0);
      check("scan.frame_done", {15'h0, frame_done}, (k % 16 == 0) ? 16'h0001 : 16'h0000);
    end

    // Mid-frame load of 12AF
    tick(5);
    in_valid = 1'b1;
    in_data  = 16'h12AF;
    tick(1);
    in_valid = 1'b0;
    check("load.in_ready_low", {15'h0, in_ready}, 16'h0000);
    check_disp("load.old_d1", 4'b1101, S0);
    wait_frame_done("load.frame_done");
    check("load.ready_at_fd", {15'h0, in_ready}, 16'h0000);
    check_disp("load.old_d3", 4'b0111, S0);
    tick(1);
    check("load.ready_after", {15'h0, in_ready}, 16'h0001);
    tick(1);
    check_disp("load.d0", 4'b1110, 7'b0001110);
    tick(4);
    check_disp("load.d1", 4'b1101, 7'b0001000);
    tick(4);
    check_disp("load.d2", 4'b1011, 7'b0100100);
    tick(4);
    check_disp("load.d3", 4'b0111, 7'b1111001);

    // Back-to-back: second value held while in_ready is low
    in_valid = 1'b1;
    in_data  = 16'h0007;
    tick(1);
    in_data  = 16'h0456;
    tick(1);
    check("b2b.fd", {15'h0, frame_done}, 16'h0001);
    check("b2b.ready_low", {15'h0, in_ready}, 16'h0000);
    tick(1);
    check("b2b.ready_high", {15'h0, in_ready}, 16'h0001);
    check_disp("b2b.old_d3", 4'b0111, 7'b1111001);
    tick(1);
    in_valid = 1'b0;
    check("b2b.second_capture", {15'h0, in_ready}, 16'h0000);
    check_disp("b2b.first_d0", 4'b1110, 7'b1111000);
    wait_frame_done("b2b.frame_done");
    tick(2);
    check_disp("b2b.d0", 4'b1110, 7'b0000010);
    tick(4);
    check_disp("b2b.d1", 4'b1101, 7'b0010010);
    tick(4);
    check_disp("b2b.d2", 4'b1011, 7'b0011001);
    tick(4);
    check_disp("b2b.d3", 4'b0111, S0);

    // Leading-zero blanking with 0030
    lz_blank = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0030;
    tick(1);
    in_valid = 1'b0;
    wait_frame_done("lz30.frame_done");
    tick(2);
    check_disp("lz30.d0", 4'b1110, S0);
    tick(4);
    check_disp("lz30.d1", 4'b1101, 7'b0110000);
    tick(4);
    check_disp("lz30.d2", 4'b1111, SB);
    tick(4);
    check_disp("lz30.d3", 4'b1111, SB);

    // 0000 with blanking: only digit 0 lit; lz_blank change waits a slot
    in_valid = 1'b1;
    in_data  = 16'h0000;
    tick(1);
    in_valid = 1'b0;
    wait_frame_done("lz0.frame_done");
    tick(2);
    check_disp("lz0.d0", 4'b1110, S0);
    tick(4);
    check_disp("lz0.d1", 4'b1111, SB);
    lz_blank = 1'b0;
    tick(1);
    check_disp("lz0.d1_same_slot", 4'b1111, SB);
    tick(3);
    check_disp("lz0.d2_next_slot", 4'b1011, S0);

    // disp_en drop mid-slot, load while dark, re-enable
    tick(1);
    disp_en = 1'b0;
    check_disp("off.before_edge", 4'b1011, S0);
    tick(1);
    check_disp("off.blank", 4'b1111, SB);
    check("off.frame_done", {15'h0, frame_done}, 16'h0000);
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    tick(1);
    in_valid = 1'b0;
    check("off.captured", {15'h0, in_ready}, 16'h0000);
    tick(1);
    check("off.committed", {15'h0, in_ready}, 16'h0001);
    disp_en = 1'b1;
    tick(1);
    check_disp("on.first_edge", 4'b1111, SB);
    tick(1);
    check_disp("on.d0", 4'b1110, 7'b0001110);
    tick(4);
    check_disp("on.d1", 4'b1101, 7'b0001110);

    // Async reset while a value is pending
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    tick(1);
    in_valid = 1'b0;
    check("ar.pending", {15'h0, in_ready}, 16'h0000);
    #2 reset = 1'b0;
    #1;
    check_disp("ar.blank", 4'b1111, SB);
    check("ar.in_ready", {15'h0, in_ready}, 16'h0001);
    check("ar.frame_done", {15'h0, frame_done}, 16'h0000);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick(1);
    in_valid = 1'b0;
    check("ar.first_capture", {15'h0, in_ready}, 16'h0000);
    check_disp("ar.r1", 4'b1111, SB);
    tick(1);
    check_disp("ar.d0_zero", 4'b1110, S0);
    tick(4);
    check_disp("ar.d1_zero", 4'b1101, S0);
    wait_frame_done("ar.frame_done");
    tick(2);
    check_disp("ar.new_d0", 4'b1110, 7'b0011001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
